apb_fsm_controller: RTL
=======================

// Module: apb_fsm_controller
// PURPOSE
//  APB-side controller of the AHB-to-APB bridge, directly downstream of the AHB slave interface.
//  Consumes valid, the Haddr/Hwdata pipeline registers and Hwrite_reg from the slave interface.
//  Sequences APB SETUP/ACCESS phases, decodes the peripheral select and stalls the AHB master
//  through Hreadyout. Registered-output Moore FSM.
// PARAMETERS
//  IC_BASE   32'h8000_0000  base of interrupt controller window (64 MB), Pselx=3'b001
//  CT_BASE   32'h8400_0000  base of counter/timer window (64 MB), Pselx=3'b010
//  RP_BASE   32'h8800_0000  base of remap/pause window (64 MB), Pselx=3'b100
// PORTS
//  Hclk       in   1   bridge clock, all state on rising edge
//  Hreset     in   1   asynchronous, active-high reset
//  valid      in   1   qualified AHB NONSEQ/SEQ transfer to APB space this cycle
//  Hwrite     in   1   AHB direction of current address phase (1=write)
//  Hwrite_reg in   1   Hwrite delayed one Hclk
//  Haddr      in   32  current AHB address
//  Haddr1     in   32  Haddr delayed 1 cycle
//  Haddr2     in   32  Haddr delayed 2 cycles
//  Hwdata     in   32  current AHB write data
//  Hwdata1    in   32  Hwdata delayed 1 cycle
//  Pready     in   1   APB slave ready (present only with APB_PREADY_EN)
//  Penable    out  1   APB enable (ACCESS phase)
//  Pwrite     out  1   APB direction
//  Pselx      out  3   one-hot APB select, decoded from the Paddr being loaded
//  Paddr      out  32  APB address
//  Pwdata     out  32  APB write data
//  Hreadyout  out  1   1 = bridge can accept next AHB transfer; 0 = wait states
// BEHAVIOUR
//  Reset (async, any state): state=ST_IDLE, Penable=0, Pwrite=0, Pselx=0, Paddr=0, Pwdata=0, Hreadyout=1.
//  Reset mid-transfer aborts the APB cycle at once; no completion is issued.
//  States: ST_IDLE, ST_WWAIT, ST_READ, ST_WRITE, ST_WRITEP, ST_RENABLE, ST_WENABLE, ST_WENABLEP.
//  Transitions:
//   IDLE, RENABLE, WENABLE: !valid->IDLE; valid&Hwrite->WWAIT; valid&!Hwrite->READ.
//   WWAIT: !valid->WRITE; valid->WRITEP.
//   READ->RENABLE.  WRITE: !valid->WENABLE; valid->WENABLEP.  WRITEP->WENABLEP.
//   WENABLEP: !Hwrite_reg->READ; Hwrite_reg&!valid->WRITE; Hwrite_reg&valid->WRITEP.
//  All outputs are registered, loaded on the edge that enters a state, from pre-edge inputs:
//   ->READ: Paddr=Haddr, Pwrite=0, Pselx=dec(Haddr), Penable=0, Hreadyout=0.
//   WWAIT->WRITE/WRITEP: Paddr=Haddr1, Pwdata=Hwdata, Pwrite=1, Pselx=dec(Haddr1), Penable=0, Hreadyout=0.
//   WENABLEP->WRITE/WRITEP: Paddr=Haddr2, Pwdata=Hwdata1, Pwrite=1, Pselx=dec(Haddr2), Penable=0.
//   ->any *ENABLE*: Penable=1, Paddr/Pwdata/Pwrite/Pselx held; Hreadyout=1 (WENABLEP: 0).
//   ->IDLE or WWAIT: Penable=0, Pselx=0, Paddr/Pwdata/Pwrite held, Hreadyout=1.
//  Latency: single read = 2 APB cycles (SETUP+ACCESS); write is delayed 1 extra cycle by WWAIT to capture data.
//  dec(a): one-hot per window; outside all three windows -> 3'b000 (SETUP/ACCESS still sequenced, no select).
//  Window bounds: [BASE, BASE+32'h0400_0000); no arithmetic wrap occurs within the window map.
//  Penable is never asserted without a non-zero state path through a SETUP state the cycle before.
// CONFIGURATION
//  APB_PREADY_EN defined: Pready port exists; in RENABLE/WENABLE/WENABLEP with Pready=0 the state
//   holds, Penable=1, Hreadyout=0, all P* held; transitions above evaluated only when Pready=1.
//  APB_PREADY_EN undefined: no Pready port; ACCESS phase is exactly one cycle (APB2 behaviour).
// TESTING
//  Reset asserted asynchronously between edges -> all outputs 0, Hreadyout=1 immediately, state IDLE.
//  Read 0x8000_0010 (valid=1,Hwrite=0, 1 cycle) -> next edge Paddr=0x8000_0010,Pselx=001,Penable=0,Hreadyout=0; then Penable=1,Hreadyout=1; then IDLE.
//  Write 0x8400_0004 data 0xA5A5_0001 -> WWAIT, WRITE(Paddr=0x8400_0004,Pwdata=0xA5A5_0001,Pselx=010), WENABLE, IDLE.
//  Back-to-back writes 0x8800_0000/0x8800_0004 -> WWAIT,WRITEP,WENABLEP,WRITE,WENABLE; second Paddr=0x8800_0004, Pselx=100.
//  Write then read 0x8000_0020 -> WENABLEP->READ; read issued with correct Paddr, Pwrite=0 after write ACCESS.
//  APB_PREADY_EN, Pready=0 for 3 cycles in RENABLE -> Penable=1,Hreadyout=0 held 3 cycles; completes on Pready=1.
//  Hreset pulse during WRITE -> IDLE, Pselx=0, Penable=0; next read starts cleanly from IDLE.

Source files
------------

// File: rtl/apb_fsm_controller.sv
// APB-side sequencer of the AHB-to-APB bridge: SETUP/ACCESS phasing, peripheral select, AHB stall.
// Optional APB3 wait states when APB_PREADY_EN is defined (adds the Pready input).
module apb_fsm_controller #(
  parameter logic [31:0] IC_BASE = 32'h8000_0000,
  parameter logic [31:0] CT_BASE = 32'h8400_0000,
  parameter logic [31:0] RP_BASE = 32'h8800_0000
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        valid,
  input  logic        Hwrite,
  input  logic        Hwrite_reg,
  input  logic [31:0] Haddr,
  input  logic [31:0] Haddr1,
  input  logic [31:0] Haddr2,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Hwdata1,
`ifdef APB_PREADY_EN
  input  logic        Pready,
`endif
  output logic        Penable,
  output logic        Pwrite,
  output logic [2:0]  Pselx,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  output logic        Hreadyout
);

  localparam logic [31:0] WIN_SIZE = 32'h0400_0000;

  // state       | meaning
  // IDLE/WWAIT  | no APB transfer / write address held, waiting one cycle for its data
  // READ/WRITE  | SETUP phase; WRITEP = SETUP with another write already pending
  // *ENABLE*    | ACCESS phase; WENABLEP = ACCESS with a pending transfer behind it
  typedef enum logic [2:0] {
    ST_IDLE, ST_WWAIT, ST_READ, ST_WRITE, ST_WRITEP, ST_RENABLE, ST_WENABLE, ST_WENABLEP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_penable, w_penable_nxt;
  logic        r_pwrite, w_pwrite_nxt;
  logic [2:0]  r_pselx, w_pselx_nxt;
  logic [31:0] r_paddr, w_paddr_nxt;
  logic [31:0] r_pwdata, w_pwdata_nxt;
  logic        r_hreadyout, w_hready_nxt;
  logic        w_pready;

`ifdef APB_PREADY_EN
  assign w_pready = Pready;
`else
  assign w_pready = 1'b1;
`endif

  function automatic logic [2:0] f_dec(input logic [31:0] a);
    logic [2:0] sel;
    sel = 3'b000;
    if (a >= IC_BASE && a < IC_BASE + WIN_SIZE) sel = 3'b001;
    if (a >= CT_BASE && a < CT_BASE + WIN_SIZE) sel = 3'b010;
    if (a >= RP_BASE && a < RP_BASE + WIN_SIZE) sel = 3'b100;
    return sel;
  endfunction

  always_comb begin
    w_state_nxt   = r_state;
    w_penable_nxt = r_penable;
    w_pwrite_nxt  = r_pwrite;
    w_pselx_nxt   = r_pselx;
    w_paddr_nxt   = r_paddr;
    w_pwdata_nxt  = r_pwdata;
    w_hready_nxt  = r_hreadyout;
    case (r_state)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        if ((r_state != ST_IDLE) && !w_pready) begin
          w_penable_nxt = 1'b1;
          w_hready_nxt  = 1'b0;
        end else if (!valid || Hwrite) begin
          w_state_nxt   = valid ? ST_WWAIT : ST_IDLE;
          w_penable_nxt = 1'b0;
          w_pselx_nxt   = 3'b000;
          w_hready_nxt  = 1'b1;
        end else begin
          w_state_nxt   = ST_READ;
          w_paddr_nxt   = Haddr;
          w_pwrite_nxt  = 1'b0;
          w_pselx_nxt   = f_dec(Haddr);
          w_penable_nxt = 1'b0;
          w_hready_nxt  = 1'b0;
        end
      end
      ST_WWAIT: begin
        // write data arrives one cycle after its address
        w_state_nxt   = valid ? ST_WRITEP : ST_WRITE;
        w_paddr_nxt   = Haddr1;
        w_pwdata_nxt  = Hwdata;
        w_pwrite_nxt  = 1'b1;
        w_pselx_nxt   = f_dec(Haddr1);
        w_penable_nxt = 1'b0;
        w_hready_nxt  = 1'b0;
      end
      ST_READ: begin
        w_state_nxt   = ST_RENABLE;
        w_penable_nxt = 1'b1;
        w_hready_nxt  = 1'b1;
      end
      ST_WRITE: begin
        w_state_nxt   = valid ? ST_WENABLEP : ST_WENABLE;
        w_penable_nxt = 1'b1;
        w_hready_nxt  = !valid;
      end
      ST_WRITEP: begin
        w_state_nxt   = ST_WENABLEP;
        w_penable_nxt = 1'b1;
        w_hready_nxt  = 1'b0;
      end
      ST_WENABLEP: begin
        if (!w_pready) begin
          w_penable_nxt = 1'b1;
          w_hready_nxt  = 1'b0;
        end else if (!Hwrite_reg) begin
          w_state_nxt   = ST_READ;
          w_paddr_nxt   = Haddr;
          w_pwrite_nxt  = 1'b0;
          w_pselx_nxt   = f_dec(Haddr);
          w_penable_nxt = 1'b0;
          w_hready_nxt  = 1'b0;
        end else begin
          // pending write sits two stages back in the address/data pipeline
          w_state_nxt   = valid ? ST_WRITEP : ST_WRITE;
          w_paddr_nxt   = Haddr2;
          w_pwdata_nxt  = Hwdata1;
          w_pwrite_nxt  = 1'b1;
          w_pselx_nxt   = f_dec(Haddr2);
          w_penable_nxt = 1'b0;
          w_hready_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_penable_nxt = 1'b0;
        w_pselx_nxt   = 3'b000;
        w_hready_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_state     <= ST_IDLE;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pselx     <= 3'b000;
      r_paddr     <= 32'h0;
      r_pwdata    <= 32'h0;
      r_hreadyout <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_pselx     <= w_pselx_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_hreadyout <= w_hready_nxt;
    end
  end

  assign Penable   = r_penable;
  assign Pwrite    = r_pwrite;
  assign Pselx     = r_pselx;
  assign Paddr     = r_paddr;
  assign Pwdata    = r_pwdata;
  assign Hreadyout = r_hreadyout;

endmodule
